// File: rtl/toggle_handshake_rx_pkg.sv
// ---------------------------------------------------------------------------
// toggle_handshake_rx_pkg
// Shared definitions for the toggle-handshake receiver: the FSM state
// encoding, default parameter values and the toggle edge helper.
// ---------------------------------------------------------------------------
package toggle_handshake_rx_pkg;

  // Receiver states: IDLE waits for a request toggle, HOLD presents a word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_COUNT_WIDTH = 8;

  // A two-phase request is signalled by any level change, so the edge is
  // simply the difference between the current and previous synced level.
  function automatic logic tgl_edge(input logic cur, input logic prev);
    return cur ^ prev;
  endfunction

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// ---------------------------------------------------------------------------
// toggle_handshake_rx_if
// Bundles the sender-side toggle handshake, the downstream valid/ready
// stream and the status/control signals of the receiver.
//   slave  : the receiver (drives ack_tgl, out_*, event_pulse, overflow,
//            xfer_count)
//   master : the environment (drives req_tgl, req_data, out_ready,
//            clear_overflow)
// ---------------------------------------------------------------------------
interface toggle_handshake_rx_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8
);
  logic                   req_tgl;
  logic [DATA_WIDTH-1:0]  req_data;
  logic                   ack_tgl;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_ready;
  logic                   event_pulse;
  logic                   overflow;
  logic                   clear_overflow;
  logic [COUNT_WIDTH-1:0] xfer_count;

  modport slave (
    input  req_tgl, req_data, out_ready, clear_overflow,
    output ack_tgl, out_valid, out_data, event_pulse, overflow, xfer_count
  );

  modport master (
    output req_tgl, req_data, out_ready, clear_overflow,
    input  ack_tgl, out_valid, out_data, event_pulse, overflow, xfer_count
  );
endinterface

// File: rtl/toggle_handshake_rx_toggle_sync.sv
// ---------------------------------------------------------------------------
// toggle_sync
// Multi-flop synchroniser for a single toggle level crossing clock domains.
// Also usable on the sender side to bring ack_tgl back.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (chain clears to 0)
//   i_d     : asynchronous input level
//   o_q     : synchronised level (STAGES clocks of latency)
// ---------------------------------------------------------------------------
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// ---------------------------------------------------------------------------
// toggle_handshake_rx
// Receiving end of a two-phase toggle handshake. The request toggle is
// synchronised, each level change captures req_data, the word is offered
// downstream with valid/ready and an acknowledge toggle is returned once it
// has been consumed. A toggle arriving while a word is still held is
// dropped and flagged in the sticky overflow bit.
// Ports:
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : toggle_handshake_rx_if.slave (req_tgl/req_data in, ack_tgl,
//             out_valid/out_data with out_ready, event_pulse, overflow with
//             clear_overflow, xfer_count)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module toggle_handshake_rx
  import toggle_handshake_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  toggle_handshake_rx_if.slave  bus
);

  logic                   w_sync;
  logic                   w_edge;
  logic                   w_accept;
  logic                   r_prev;
  logic                   r_event;
  state_t                 r_state;
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_ack;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_overflow;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (bus.req_tgl),
    .o_q     (w_sync)
  );

  assign w_edge   = tgl_edge(w_sync, r_prev);
  assign w_accept = r_valid & bus.out_ready;

  // Remember the last synced level and register the edge as event_pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev  <= 1'b0;
      r_event <= 1'b0;
    end else begin
      r_prev  <= w_sync;
      r_event <= w_edge;
    end
  end

  // Receiver FSM: capture on a toggle in IDLE, release and ack on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_data  <= bus.req_data;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // A toggle seen here is dropped; only the accept changes state.
          if (w_accept) begin
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
            r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a toggle while holding sets it, and set beats clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_edge && (r_state == ST_HOLD)) begin
      r_overflow <= 1'b1;
    end else if (bus.clear_overflow) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign bus.ack_tgl     = r_ack;
  assign bus.out_valid   = r_valid;
  assign bus.out_data    = r_data;
  assign bus.event_pulse = r_event;
  assign bus.overflow    = r_overflow;
  assign bus.xfer_count  = r_count;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// ---------------------------------------------------------------------------
// tb_toggle_handshake_rx
// Scoreboard bench: the sender side pushes every word it expects delivered;
// a negedge monitor pops and compares whenever the receiver hands a word
// downstream. Directed sections cover reset, latency, backpressure,
// overflow and reset in mid-transfer; a randomised run covers counter wrap.
// ---------------------------------------------------------------------------
module tb_toggle_handshake_rx;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  toggle_handshake_rx_if #(.DATA_WIDTH(16), .COUNT_WIDTH(8)) bus ();

  toggle_handshake_rx #(
    .SYNC_STAGES (2),
    .DATA_WIDTH  (16),
    .COUNT_WIDTH (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          model_count = 0;
  bit          mon_en = 1'b0;
  logic [15:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed on the next rising edge when valid and ready
  // are both seen high here.
  always @(negedge clock) begin
    if (mon_en && reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_order", {16'h0, bus.out_data}, {16'h0, mon_e});
        check("count_before_accept", {24'h0, bus.xfer_count}, model_count % 256);
        check("ack_before_accept", {31'h0, bus.ack_tgl}, model_count % 2);
        model_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit expect_it);
    bus.req_data = d;
    if (expect_it) exp_q.push_back(d);
    bus.req_tgl = ~bus.req_tgl;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    check(name, {31'h0, bus.out_valid}, 32'd1);
  endtask

  task automatic wait_event(input string name);
    int n = 0;
    tick();
    while (!bus.event_pulse && n < 50) begin
      tick();
      n++;
    end
    check(name, {31'h0, bus.event_pulse}, 32'd1);
  endtask

  task automatic wait_ack_change(input string name);
    logic a;
    int   n = 0;
    a = bus.ack_tgl;
    while (bus.ack_tgl == a && n < 200) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    check(name, {31'h0, bus.ack_tgl}, {31'h0, ~a});
  endtask

  logic [15:0] bp_word;

  initial begin
    bus.req_tgl        = 1'b0;
    bus.req_data       = 16'h0;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    reset_n            = 1'b0;

    // Reset held: toggles must not reach the outputs.
    tick();
    bus.req_tgl = 1'b1;
    tick();
    tick();
    check("rst_event", {31'h0, bus.event_pulse}, 32'd0);
    check("rst_valid", {31'h0, bus.out_valid}, 32'd0);
    bus.req_tgl = 1'b0;
    tick();
    tick();
    check("rst_ack", {31'h0, bus.ack_tgl}, 32'd0);
    check("rst_data", {16'h0, bus.out_data}, 32'd0);
    check("rst_overflow", {31'h0, bus.overflow}, 32'd0);
    check("rst_count", {24'h0, bus.xfer_count}, 32'd0);
    reset_n = 1'b1;
    repeat (5) begin
      tick();
      check("idle_valid", {31'h0, bus.out_valid}, 32'd0);
      check("idle_event", {31'h0, bus.event_pulse}, 32'd0);
    end
    mon_en = 1'b1;

    // Single transfer with exact latency: toggle before edge E1.
    bus.out_ready = 1'b1;
    send(16'h1234, 1'b1);
    tick();
    check("lat_e1_valid", {31'h0, bus.out_valid}, 32'd0);
    tick();
    check("lat_e2_valid", {31'h0, bus.out_valid}, 32'd0);
    tick();
    check("lat_e3_valid", {31'h0, bus.out_valid}, 32'd1);
    check("lat_e3_data", {16'h0, bus.out_data}, 32'h1234);
    check("lat_e3_event", {31'h0, bus.event_pulse}, 32'd1);
    tick();
    check("lat_e4_valid", {31'h0, bus.out_valid}, 32'd0);
    check("lat_e4_event", {31'h0, bus.event_pulse}, 32'd0);
    check("single_ack", {31'h0, bus.ack_tgl}, 32'd1);
    check("single_count", {24'h0, bus.xfer_count}, 32'd1);

    // Backpressure: word held stable for 10 cycles, then consumed once.
    bus.out_ready = 1'b0;
    bp_word = 16'($urandom);
    send(bp_word, 1'b1);
    wait_valid("bp_valid_arrive");
    repeat (10) begin
      tick();
      check("bp_valid_hold", {31'h0, bus.out_valid}, 32'd1);
      check("bp_data_hold", {16'h0, bus.out_data}, {16'h0, bp_word});
      check("bp_ack_hold", {31'h0, bus.ack_tgl}, 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_ack_toggle", {31'h0, bus.ack_tgl}, 32'd0);
    check("bp_valid_fall", {31'h0, bus.out_valid}, 32'd0);
    check("bp_count", {24'h0, bus.xfer_count}, 32'd2);
    bus.out_ready = 1'b0;
    tick();
    check("bp_data_after", {16'h0, bus.out_data}, {16'h0, bp_word});

    // Overflow: a second toggle while holding is dropped and flagged.
    send(16'h1234, 1'b1);
    wait_valid("ovf_valid_arrive");
    check("ovf_clear_start", {31'h0, bus.overflow}, 32'd0);
    send(16'hBEEF, 1'b0);
    wait_event("ovf_event");
    check("ovf_set", {31'h0, bus.overflow}, 32'd1);
    check("ovf_data_kept", {16'h0, bus.out_data}, 32'h1234);
    check("ovf_ack_kept", {31'h0, bus.ack_tgl}, 32'd0);
    bus.clear_overflow = 1'b1;
    send(16'hCAFE, 1'b0);
    wait_event("ovf_event2");
    bus.clear_overflow = 1'b0;
    check("ovf_set_wins", {31'h0, bus.overflow}, 32'd1);
    check("ovf_data_kept2", {16'h0, bus.out_data}, 32'h1234);
    tick();
    check("ovf_sticky", {31'h0, bus.overflow}, 32'd1);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    check("ovf_cleared", {31'h0, bus.overflow}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("ovf_drain_valid", {31'h0, bus.out_valid}, 32'd0);
    check("ovf_drain_count", {24'h0, bus.xfer_count}, 32'd3);
    check("ovf_drain_ack", {31'h0, bus.ack_tgl}, 32'd1);
    bus.out_ready = 1'b0;

    // Reset while a word is held: it is discarded immediately.
    send(16'h0F0F, 1'b1);
    wait_valid("rmid_valid_arrive");
    #2;
    reset_n = 1'b0;
    bus.req_tgl = 1'b0;
    #1;
    check("rmid_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rmid_ack", {31'h0, bus.ack_tgl}, 32'd0);
    check("rmid_count", {24'h0, bus.xfer_count}, 32'd0);
    exp_q.delete();
    model_count = 0;
    tick();
    tick();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) begin
      tick();
      check("rmid_no_delivery", {31'h0, bus.out_valid}, 32'd0);
    end

    // Wrap: 256 randomised handshakes driven by a sender reacting to ack.
    for (int i = 0; i < 256; i++) begin
      send(16'($urandom), 1'b1);
      wait_ack_change("wrap_ack");
    end
    bus.out_ready = 1'b0;
    repeat (4) tick();
    check("wrap_count", {24'h0, bus.xfer_count}, 32'd0);
    check("wrap_ack_final", {31'h0, bus.ack_tgl}, 32'd0);
    check("wrap_delivered", model_count, 32'd256);
    check("wrap_queue_empty", exp_q.size(), 32'd0);
    check("wrap_no_overflow", {31'h0, bus.overflow}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/toggle_handshake_rx.md
Name: toggle_handshake_rx

Overview:
- Receiving end of the two-phase toggle handshake whose sender holds a T-flip-flop request toggle plus a data word.
- Synchronises the asynchronous request toggle into the local clock domain and captures the data word on each detected toggle.
- Presents the word downstream with valid/ready, then returns an acknowledge toggle to the sender once the word is consumed.
- Used between ND-120 subsystems clocked from different sources, e.g. a panel/IO domain to the CPU domain.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on req_tgl; legal range 2..4.
- DATA_WIDTH, 16, width of the transferred word.
- COUNT_WIDTH, 8, width of the accepted-transfer counter.

Ports:
- clock  in  1  Sole clock; all state updates on its rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- req_tgl  in  1  Request toggle from the sender domain, asynchronous to clock; each level change is one transfer.
- req_data  in  DATA_WIDTH  Sender word; stable from before the req_tgl change until the sender sees ack_tgl change.
- ack_tgl  out  1  Acknowledge toggle back to the sender; changes level once per consumed word.
- out_valid  out  1  Captured word available.
- out_data  out  DATA_WIDTH  Captured word; stable while out_valid=1.
- out_ready  in  1  Downstream accepts the word when out_valid=1.
- event_pulse  out  1  One-cycle pulse on every detected req_tgl change, including dropped ones.
- overflow  out  1  Sticky flag: a request toggle arrived while a word was still held.
- clear_overflow  in  1  Synchronous clear of overflow.
- xfer_count  out  COUNT_WIDTH  Number of consumed words; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - Synchroniser chain, prev_q, ack_tgl, out_valid, out_data, overflow, xfer_count and event_pulse are all 0.
  - State is IDLE.
  - Sender and receiver must be reset together. Reset mid-transfer discards any held word, and ack_tgl returns to 0.
- Synchroniser:
  - sync[0] samples req_tgl every clock; sync[i] takes sync[i-1].
  - The edge is detected combinationally as edge = sync[SYNC_STAGES-1] ^ prev_q.
  - prev_q takes sync[SYNC_STAGES-1] every clock.
- event_pulse is the registered edge: exactly 1 cycle high per req_tgl change.
- State machine has two states, IDLE and HOLD.
  - IDLE, edge=1: out_data <= req_data, out_valid <= 1, go to HOLD.
  - HOLD, out_valid=1 and out_ready=1: out_valid <= 0, ack_tgl <= ~ack_tgl, xfer_count <= xfer_count+1, go to IDLE.
  - HOLD, edge=1 (protocol violation): the new word is dropped, overflow <= 1, and out_data/ack_tgl are unchanged. This also applies when the edge coincides with the accept; the accept still completes.
- Latency:
  - out_valid rises SYNC_STAGES+1 rising edges after the first edge that samples the new req_tgl level.
  - ack_tgl toggles on the edge that completes the accept.
  - out_valid falls on the same edge as the ack_tgl toggle.
- out_ready is ignored while out_valid=0. out_data holds its last value after the accept.
- overflow:
  - Set and clear in the same cycle: set wins.
  - Cleared only by clear_overflow or reset.
- xfer_count wraps from all-ones to 0 with no flag.
- No combinational path from any input to any output.

Decomposition:
- Shared include/package holds the state encodings (ST_IDLE=1'b0, ST_HOLD=1'b1) and the default SYNC_STAGES constant.
- One natural sub-module, toggle_sync: a SYNC_STAGES-deep flop chain with asynchronous active-low reset. It is reused for the sender-side ack synchroniser.

Test Plan:
- Reset: hold reset_n=0, toggle req_tgl -> all outputs 0, no event_pulse. Release reset -> still idle.
- Single transfer: SYNC_STAGES=2, req_data=16'h1234, req_tgl 0->1, out_ready=1:
  - out_valid high for 1 cycle, 3 edges after sampling, with out_data=16'h1234.
  - ack_tgl goes 0->1; xfer_count=1.
- Backpressure: out_ready=0 for 10 cycles after the word arrives -> out_valid and out_data stable, ack_tgl unchanged. Raise out_ready -> ack_tgl toggles once.
- Overflow: while in HOLD, toggle req_tgl again with data 16'hBEEF:
  - event_pulse fires, overflow=1, out_data stays 16'h1234.
  - Assert clear_overflow together with a further violation -> overflow stays 1.
  - Then clear_overflow alone -> overflow=0.
- Wrap: 256 back-to-back handshakes driven by a sender model reacting to ack_tgl -> xfer_count returns to 0, and every word is received in order.
- Reset mid-operation: assert reset_n=0 while out_valid=1 -> out_valid and ack_tgl drop to 0 immediately (asynchronous), and the held word is not delivered.
